bash_f_sched: RTL
=================

# bash_f_sched

Round scheduler for the bash-f permutation datapath. Accepts a start request, issues a one-cycle state-load strobe and then sequences `ROUNDS` round-enable strobes, presenting each round's 64-bit constant and index to the round datapath. Holds a result-valid flag until the consumer acknowledges it. Generates the constant sequence C1..C24 internally with a one-step-per-round LFSR update in byte-reversed (little-endian lane) storage format, so no separate constant block is instantiated.

## Interface

- `ROUNDS`, 24: number of round strobes per permutation; legal range 1..31.
- `RND_LAT`, 1: datapath cycles per round, ≥1. The next round strobe is issued `RND_LAT` cycles after the previous one.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: request a permutation; sampled only in IDLE.
- `ready_o` out 1: high in IDLE (start will be accepted).
- `load_o` out 1: one-cycle strobe; the datapath loads the new input state.
- `rnd_en_o` out 1: one-cycle strobe; the datapath executes one round using `rc_o`/`round_o`.
- `round_o` out 5: current round index, 1..`ROUNDS`.
- `rc_o` out 64: current round constant, byte-reversed lane format.
- `valid_o` out 1: permutation result valid; held until acknowledged.
- `ack_i` in 1: consumer acknowledge; used only while `valid_o`=1.

## Operation

- States: IDLE, LOAD, ROUND, WAIT, DONE.
  - **IDLE**: `ready_o`=1. On `start_i`=1, go to LOAD. Otherwise stay.
  - **LOAD**: `load_o`=1 for one cycle. `round_o`=1, `rc_o`=C1. Go to ROUND.
  - **ROUND**: `rnd_en_o`=1 for one cycle.
    - If `round_o`=`ROUNDS`, go to DONE.
    - Else if `RND_LAT`=1, stay in ROUND.
    - Else go to WAIT.
    - On every cycle in ROUND except the last round, on the clock edge: `round_o` increments and `rc_o` steps.
  - **WAIT**: counts `RND_LAT`-1 cycles with all strobes low, then returns to ROUND.
  - **DONE**: `valid_o`=1. On `ack_i`=1, go to IDLE. `rc_o`/`round_o` reload to C1/1 on that transition.
- `start_i` outside IDLE is ignored, not queued. `ack_i` outside DONE is ignored.
- C1 in storage format is 64'hB194BAC80A08F53B (numeric 0x3BF5080AC8BA94B1).
- Constant step from value x:
  - Byte-reverse x.
  - Logical shift right by 1, zero-filling the MSB.
  - Byte-reverse the result.
  - XOR with 64'hAED8E07F99E12BDC if and only if x[56]=1.
- `round_o` is a 5-bit counter with no wrap. It never exceeds `ROUNDS`.
- `load_o`, `rnd_en_o` and `valid_o` are never high in the same cycle.

## Timing

- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Reset values (async on `rst_n`=0):
  - State IDLE, `ready_o`=1.
  - `load_o`=0, `rnd_en_o`=0, `valid_o`=0.
  - `round_o`=1, `rc_o`=C1.
  - WAIT counter 0.
- Start accepted at edge T:
  - `load_o` high in cycle T+1.
  - Round k strobe (`rnd_en_o`) high in cycle T+2+(k-1)·`RND_LAT`.
  - `valid_o` rises in cycle T+2+(`ROUNDS`-1)·`RND_LAT`+1.
- Defaults (`ROUNDS`=24, `RND_LAT`=1): load at T+1, rounds at T+2..T+25, `valid_o` at T+26.
- `ack_i` high in the same cycle as `valid_o`: `valid_o` is low in the next cycle and `ready_o` is high. A new start may be accepted in that IDLE cycle, which is the minimum 1-cycle gap.
- Reset asserted mid-run: immediate return to reset values. No strobes are issued after reset, and any partial permutation is abandoned.
- `rc_o` and `round_o` are stable from the cycle of their strobe until the next strobe.

## Test plan

- **Reset**: assert `rst_n`=0 mid-ROUND at round 10 → next cycle `ready_o`=1, `round_o`=1, `rc_o`=64'hB194BAC80A08F53B, all strobes 0.
- **Default run**: start pulse at T → `load_o` at T+1, 24 consecutive `rnd_en_o` pulses with `round_o` 1..24, `valid_o` at T+26. The round-2 `rc_o` must equal 64'hF692BD1B9C65D1C1 (numeric 0xC1D1659C1BBD92F6). All 24 constants must match the reference model of the step rule.
- **Slow datapath** (`RND_LAT`=3): `rnd_en_o` pulses are 3 cycles apart. The last pulse is at T+71 and `valid_o` rises at T+72. `rc_o` is constant between pulses.
- **Backpressure**: hold `ack_i`=0 for 50 cycles after `valid_o` → `valid_o` stays 1. Pulse `start_i` during that window → ignored, no `load_o`. Assert `ack_i` → IDLE next cycle.
- **Back-to-back**: `ack_i` with `valid_o`, then `start_i` in the following IDLE cycle → second run starts with `round_o`=1, `rc_o`=C1, and the same timing as the first run.
- **Spurious inputs**: `start_i` held high continuously → exactly one run per IDLE visit. `ack_i` toggling during ROUND → no effect on the sequence.

Source files
------------

// File: rtl/bash_f_sched.sv
// rtl/bash_f_sched.sv - bash-f permutation round scheduler with internal round-constant LFSR
// Sequences load, ROUNDS round strobes spaced RND_LAT apart, then holds valid until ack.
module bash_f_sched #(
   parameter int ROUNDS  = 24,
   parameter int RND_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   output logic        ready_o,
   output logic        load_o,
   output logic        rnd_en_o,
   output logic [4:0]  round_o,
   output logic [63:0] rc_o,
   output logic        valid_o,
   input  logic        ack_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROUND = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [63:0] RC_INIT    = 64'hB194BAC80A08F53B;
   localparam logic [63:0] RC_POLY    = 64'hAED8E07F99E12BDC;
   localparam logic [4:0]  ROUND_LAST = 5'(ROUNDS);
   localparam int          WAIT_LAST_I = (RND_LAT > 1) ? RND_LAT - 2 : 0;
   localparam logic [15:0] WAIT_LAST  = 16'(WAIT_LAST_I);

   state_t      state_q;
   state_t      state_d;
   logic [4:0]  round_q;
   logic [63:0] rc_q;
   logic [63:0] rc_next;
   logic [15:0] wait_cnt_q;
   logic        last_round;

   function automatic logic [63:0] bswap64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = x[8*(7-i) +: 8];
      end
      return r;
   endfunction

   // Constants are kept byte-reversed; the shift happens in numeric order and
   // x[56] is the numeric LSB, so this is a Galois LFSR step in lane format.
   assign rc_next    = bswap64(bswap64(rc_q) >> 1) ^ (rc_q[56] ? RC_POLY : 64'd0);
   assign last_round = (round_q == ROUND_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_LOAD;
         S_LOAD:  state_d = S_ROUND;
         S_ROUND: begin
            if (last_round)        state_d = S_DONE;
            else if (RND_LAT == 1) state_d = S_ROUND;
            else                   state_d = S_WAIT;
         end
         S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_ROUND;
         S_DONE:  if (ack_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_o  = (state_q == S_IDLE);
      load_o   = (state_q == S_LOAD);
      rnd_en_o = (state_q == S_ROUND);
      valid_o  = (state_q == S_DONE);
   end

   // Round index and constant advance on leaving each non-final round, so
   // they stay stable through WAIT and are already correct at the next strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_q    <= 5'd1;
         rc_q       <= RC_INIT;
         wait_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            S_ROUND: begin
               wait_cnt_q <= 16'd0;
               if (!last_round) begin
                  round_q <= round_q + 5'd1;
                  rc_q    <= rc_next;
               end
            end
            S_WAIT: begin
               wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            S_DONE: begin
               if (ack_i) begin
                  round_q <= 5'd1;
                  rc_q    <= RC_INIT;
               end
            end
            default: begin
               wait_cnt_q <= wait_cnt_q;
            end
         endcase
      end
   end

   assign round_o = round_q;
   assign rc_o    = rc_q;

endmodule
